// File: rtl/weight_buffer_loader.sv
// Write-side feeder for the weight buffer: turns a DDR beat stream into per-group
// BRAM writes (shared data/row address, one-hot-group write enable), row by row.
module weight_buffer_loader #(
  parameter int X_PE         = 16,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int DDR_DATA_LEN = 256,
  parameter int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN,
  parameter int LANES        = DDR_DATA_LEN / DATA_LEN,
  parameter int GROUPS       = BUFFER_NUM / LANES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [ADDR_LEN-1:0]     cfg_base_addr,
  input  logic [ADDR_LEN:0]       cfg_rows,
  input  logic [DDR_DATA_LEN-1:0] ddr_data,
  input  logic                    ddr_valid,
  output logic                    ddr_ready,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    busy,
  output logic                    done
);

  localparam int GRP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GRP_W-1:0]      r_grp;
  logic [ADDR_LEN-1:0]   r_row_addr;
  logic [ADDR_LEN:0]     r_rows_left;
  logic                  w_accept;
  logic                  w_grp_last;
  logic                  w_last_beat;
  logic [BUFFER_NUM-1:0] w_en_mask;

  assign w_accept    = ddr_valid && (r_state == S_LOAD);
  assign w_grp_last  = (r_grp == GRP_W'(GROUPS - 1));
  assign w_last_beat = w_accept && w_grp_last && (r_rows_left == (ADDR_LEN+1)'(1));

  always_comb begin
    w_en_mask = '0;
    w_en_mask[int'(r_grp) * LANES +: LANES] = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Handshake and status are decoded from state alone, so ready never depends on valid.
  always_comb begin
    w_state_nxt = r_state;
    ddr_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (cfg_start)
          w_state_nxt = (cfg_rows == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        ddr_ready = 1'b1;
        if (w_last_beat) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grp       <= '0;
      r_row_addr  <= '0;
      r_rows_left <= '0;
    end else if (r_state == S_IDLE) begin
      if (cfg_start) begin
        r_grp       <= '0;
        r_row_addr  <= cfg_base_addr;
        r_rows_left <= cfg_rows;
      end
    end else if (w_accept) begin
      if (w_grp_last) begin
        r_grp       <= '0;
        r_row_addr  <= r_row_addr + 1'b1;
        r_rows_left <= r_rows_left - 1'b1;
      end else begin
        r_grp <= r_grp + 1'b1;
      end
    end
  end

  // Write port: one cycle behind the accepted beat; data/address hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_wr <= '0;
      wr_addr <= '0;
      wr_en   <= '0;
    end else begin
      wr_en <= w_accept ? w_en_mask : '0;
      if (w_accept) begin
        data_wr <= ddr_data;
        wr_addr <= r_row_addr;
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Directed bench for weight_buffer_loader: table of load cases plus hand-written
// sequences for zero rows and asynchronous reset mid-load.
module tb_weight_buffer_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic [15:0]  cfg_base_addr;
  logic [16:0]  cfg_rows;
  logic [255:0] ddr_data;
  logic         ddr_valid;
  logic         ddr_ready;
  logic [255:0] data_wr;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_en;
  logic         busy;
  logic         done;

  int nerr = 0;
  int nchk = 0;

  weight_buffer_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_rows(cfg_rows), .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
    .data_wr(data_wr), .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] base;
    logic [16:0] rows;
    int          gap;        // 0: valid held high, 1: valid toggles 1,0,1,0
    int          inj;        // cycle index of a stray cfg_start, -1 for none
    int          exp_writes;
    logic [15:0] exp_last_addr;
  } case_t;

  case_t       cases[5];
  logic [31:0] en_pat[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] bd(input int b);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(k * 268435456 + b * 7 + 3);
    return r;
  endfunction

  // Runs one load from the IDLE state; called at posedge+1.
  task automatic run_case(input case_t c);
    int   beats, total, cyc, wr, pb;
    logic exp_acc, exp_rdy, seen_done;
    total = int'(c.rows) * 8;
    cfg_base_addr = c.base;
    cfg_rows      = c.rows;
    cfg_start     = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    beats = 0; wr = 0; cyc = 0; pb = 0; exp_acc = 1'b0; seen_done = 1'b0;
    while (!seen_done && cyc < 400) begin
      if (cyc > 0) begin
        if (exp_acc) begin
          chk({c.name, " wr_en"},   256'(wr_en),   256'(en_pat[pb % 8]));
          chk({c.name, " wr_addr"}, 256'(wr_addr), 256'(16'(c.base + 16'(pb / 8))));
          chk({c.name, " data_wr"}, data_wr,       bd(pb));
          chk({c.name, " done"},    256'(done),    256'(pb == total - 1));
          wr++;
          if (pb == total - 1) seen_done = 1'b1;
        end else begin
          chk({c.name, " gap wr_en"}, 256'(wr_en), 256'(0));
          chk({c.name, " gap done"},  256'(done),  256'(0));
        end
      end
      if (!seen_done) begin
        exp_rdy = (beats < total);
        chk({c.name, " ddr_ready"}, 256'(ddr_ready), 256'(exp_rdy));
        chk({c.name, " busy"},      256'(busy),      256'(1));
        ddr_valid     = (c.gap == 0) ? 1'b1 : (cyc % 2 == 0);
        ddr_data      = bd(beats);
        cfg_start     = (cyc == c.inj);
        cfg_base_addr = 16'h0100;
        cfg_rows      = 17'd1;
        exp_acc = ddr_valid && exp_rdy;
        pb = beats;
        if (exp_acc) beats++;
        cyc++;
        @(posedge clk); #1;
        cfg_start = 1'b0;
      end
    end
    if (!seen_done) begin
      nchk++; nerr++;
      $display("FAIL %s timeout: writes %0d expected %0d", c.name, wr, c.exp_writes);
    end
    chk({c.name, " ready in done cycle"}, 256'(ddr_ready), 256'(0));
    chk({c.name, " busy in done cycle"},  256'(busy),      256'(1));
    ddr_valid = 1'b0;
    chk({c.name, " write count"}, 256'(wr),      256'(c.exp_writes));
    chk({c.name, " last addr"},   256'(wr_addr), 256'(c.exp_last_addr));
    @(posedge clk); #1;
    chk({c.name, " busy after"}, 256'(busy),  256'(0));
    chk({c.name, " done after"}, 256'(done),  256'(0));
    chk({c.name, " wr_en after"}, 256'(wr_en), 256'(0));
  endtask

  initial begin
    en_pat[0] = 32'h0000000F; en_pat[1] = 32'h000000F0;
    en_pat[2] = 32'h00000F00; en_pat[3] = 32'h0000F000;
    en_pat[4] = 32'h000F0000; en_pat[5] = 32'h00F00000;
    en_pat[6] = 32'h0F000000; en_pat[7] = 32'hF0000000;
    cases[0] = '{"basic",      16'h0010, 17'd2, 0, -1, 16, 16'h0011};
    cases[1] = '{"backpress",  16'h0010, 17'd2, 1, -1, 16, 16'h0011};
    cases[2] = '{"wrap",       16'hFFFF, 17'd2, 0, -1, 16, 16'h0000};
    cases[3] = '{"ign_start",  16'h0000, 17'd1, 0,  3,  8, 16'h0000};
    cases[4] = '{"post_reset", 16'h0030, 17'd1, 1, -1,  8, 16'h0030};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_rows = '0;
    ddr_data = '0; ddr_valid = 1'b0;
    #3;
    chk("reset wr_en",   256'(wr_en),     256'(0));
    chk("reset data_wr", data_wr,         256'(0));
    chk("reset wr_addr", 256'(wr_addr),   256'(0));
    chk("reset ready",   256'(ddr_ready), 256'(0));
    chk("reset busy",    256'(busy),      256'(0));
    chk("reset done",    256'(done),      256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_case(cases[i]);
      if (i == 3) begin
        repeat (3) @(posedge clk);
        #1;
        chk("ign_start stays idle", 256'(busy), 256'(0));
      end
    end

    // Zero rows: straight to DONE without ever offering ready.
    ddr_valid = 1'b1;
    cfg_base_addr = 16'h0040; cfg_rows = 17'd0; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("zero done",  256'(done),      256'(1));
    chk("zero ready", 256'(ddr_ready), 256'(0));
    chk("zero busy",  256'(busy),      256'(1));
    @(posedge clk); #1;
    chk("zero wr_en",      256'(wr_en),     256'(0));
    chk("zero done after", 256'(done),      256'(0));
    chk("zero busy after", 256'(busy),      256'(0));
    chk("zero ready idle", 256'(ddr_ready), 256'(0));
    ddr_valid = 1'b0;

    // Asynchronous reset after the fifth accepted beat.
    cfg_base_addr = 16'h0020; cfg_rows = 17'd2; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    ddr_valid = 1'b1;
    ddr_data  = bd(99);
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset wr_en", 256'(wr_en), 256'(32'h000F0000));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async wr_en", 256'(wr_en),     256'(0));
    chk("async ready", 256'(ddr_ready), 256'(0));
    chk("async busy",  256'(busy),      256'(0));
    chk("async done",  256'(done),      256'(0));
    ddr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset hold done", 256'(done), 256'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_case(cases[4]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/weight_buffer_loader.md
Name: weight_buffer_loader

Overview:
- Write-side feeder for the weight buffer. It takes a DDR read stream of DDR_DATA_LEN-bit beats over a valid/ready handshake.
- It converts the stream into the buffer's write port: a shared data word, a shared row address, and a per-BRAM write-enable vector.
- Each beat fills one group of LANES adjacent BRAMs at the current row. Groups are visited in order, then the row advances.
- It sits between the DDR read DMA and the weight buffer write inputs (data_wr / wr_addr / wr_en).

Parameters:
- X_PE, 16, PE count per mesh
- X_MESH, 16, mesh count
- ADDR_LEN, 16, buffer row address width
- DATA_LEN, 64, width of one BRAM word
- DDR_DATA_LEN, 256, DDR beat width
- BUFFER_NUM, 8*X_PE*X_MESH/DATA_LEN, number of BRAMs (32 by default)
- LANES, DDR_DATA_LEN/DATA_LEN, BRAMs written per beat (4)
- GROUPS, BUFFER_NUM/LANES, beats per buffer row (8)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle request to start a load; sampled only in IDLE
- cfg_base_addr  in  ADDR_LEN  first buffer row to write
- cfg_rows  in  ADDR_LEN+1  number of rows to fill; 0 is legal
- ddr_data  in  DDR_DATA_LEN  DDR beat payload
- ddr_valid  in  1  DDR beat valid
- ddr_ready  out  1  loader accepts a beat
- data_wr  out  DDR_DATA_LEN  write data to the buffer
- wr_addr  out  ADDR_LEN  write row address to the buffer
- wr_en  out  BUFFER_NUM  per-BRAM write enable
- busy  out  1  a load is in progress
- done  out  1  one-cycle pulse marking the end of a load

Behaviour:
- Reset (async, rst_n=0): state=IDLE; data_wr=0, wr_addr=0, wr_en=0, done=0, busy=0, ddr_ready=0; all counters cleared. These take effect immediately, independent of clk.
- States:
  - IDLE: cfg_start=1 latches cfg_base_addr into row_addr and cfg_rows into rows_left, and clears grp.
    - rows_left==0 -> DONE.
    - otherwise -> LOAD.
  - LOAD: ddr_ready=1, decoded combinationally from state only. A beat is accepted on a rising edge where ddr_valid&ddr_ready=1.
  - DONE: lasts one cycle, done=1, then -> IDLE.
- Outputs: busy = (state!=IDLE); ddr_ready = (state==LOAD).
- Per accepted beat (registered, 1-cycle latency): in the next cycle the outputs are
  - data_wr = ddr_data
  - wr_addr = row_addr
  - wr_en = LANES ones at bits [grp*LANES +: LANES], zeros elsewhere.
- Cycles with no accepted beat: wr_en=0. data_wr and wr_addr hold their previous values.
- Counter update after each accepted beat:
  - grp increments.
  - At grp==GROUPS-1: grp wraps to 0, row_addr increments modulo 2^ADDR_LEN, rows_left decrements.
- Last beat: the beat accepted with grp==GROUPS-1 and rows_left==1.
  - LOAD -> DONE.
  - The last write's wr_en and done=1 appear in the same cycle.
  - ddr_ready is 0 in that cycle.
- Total write cycles per load = cfg_rows*GROUPS. Each wr_en bit is asserted exactly cfg_rows times.
- cfg_start outside IDLE (LOAD, DONE) is ignored. cfg_* inputs are not re-sampled.
- Row address wrap: 2^ADDR_LEN-1 -> 0, with no error flag.
- Back-to-back loads: cfg_start in the cycle after done (state back in IDLE) is accepted.
- Downstream: the weight buffer registers the write port once more internally. The loader does no read/write collision checking; that is the controller's responsibility.
- rst_n asserted mid-LOAD: everything aborts, and no done pulse is produced. A partially written row is left as-is.

Test Plan:
- Basic load, defaults:
  - Stimulus: cfg_start with base=0x0010, rows=2; ddr_valid held 1; 16 beats.
  - Required: wr_en = 0x0000000F, 0x000000F0, …, 0xF0000000 at wr_addr=0x0010, then the same 8 patterns at 0x0011. data_wr equals each beat. done=1 together with the 16th write; busy falls the cycle after.
- Backpressure:
  - Stimulus: same load with ddr_valid toggling 1,0,1,0.
  - Required: writes occur only on cycles following an accepted beat. Order and addresses are identical to the basic load. wr_en=0 in gap cycles. Exactly 16 writes.
- Zero rows:
  - Stimulus: cfg_start, rows=0.
  - Required: ddr_ready never 1, wr_en never nonzero. done=1 in the cycle after start, then IDLE.
- Address wrap:
  - Stimulus: base=0xFFFF, rows=2.
  - Required: 8 writes at 0xFFFF, then 8 writes at 0x0000, then done.
- Ignored start:
  - Stimulus: cfg_start with base=0x0100, rows=1 issued mid-load of a base=0x0000, rows=1 load.
  - Required: only rows 0x0000 are written, 8 writes, single done pulse.
- Async reset mid-load:
  - Stimulus: rst_n=0 for 3 cycles after the 5th beat.
  - Required: wr_en=0, ddr_ready=0, busy=0 immediately with no clock edge, and no done. A subsequent start with rows=1 produces 8 clean writes and done.
